seg7_value_encoder: RTL
=======================

Name: seg7_value_encoder

Overview:
- Upstream stage of the two-digit 7-segment multiplexer; produces the 14-bit both7seg word that block consumes.
- Takes a 7-bit binary value on a start strobe, converts it to two BCD digits with serial double-dabble, and decodes each digit to a segment pattern.
- Holds the registered result stable until the next conversion, so the multiplexer always samples a coherent pair.

Parameters:
- BLANK_LEADING, 1: 1 = tens digit dark when it is 0; 0 = tens digit shows "0".
- ACTIVE_LOW, 0: 1 = invert every both7seg bit (common-anode displays). Applies to the reset value too.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- value  input  7  binary value to display, 0..127.
- start  input  1  conversion request; sampled only in IDLE.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when both7seg is updated.
- both7seg  output  14  [13:7] = tens pattern, [6:0] = units pattern; bit 6 = g ... bit 0 = a; 1 = lit (before ACTIVE_LOW).

Behaviour:
- Reset is synchronous and active-high; clock and reset are clk and rst.
- Reset values:
  - busy = 0, done = 0, state = IDLE.
  - both7seg = all segments dark: 14'h0000, or 14'h3FFF when ACTIVE_LOW = 1.
- States:
  - IDLE: on start = 1, capture value into the shift register, clear the BCD nibbles and bit counter, go to SHIFT, set busy = 1.
  - SHIFT: 7 cycles. Each cycle, add 3 to any BCD nibble >= 5, then shift the {tens, units, bin} register left by 1. After the 7th shift, go to ENCODE.
  - ENCODE: 1 cycle. Register the decoded patterns into both7seg, pulse done = 1 for one cycle, clear busy, return to IDLE.
- Latency: start sampled at edge N; both7seg updates and done rises after edge N+8; busy is high from edge N to edge N+8.
- Captured value is the one present at edge N. Changes on value while busy are ignored.
- start while busy is ignored; it is not queued.
- start in the cycle done is high is accepted, since the state is IDLE.
- Overflow: captured value > 99 gives both digits = dash (7'h40). Overflow is decided from the captured value at capture time; the BCD result is discarded.
- Leading blank: tens = 0 and BLANK_LEADING = 1 gives tens pattern 7'h00. The units digit is always shown, so 0 displays as "_0".
- Digit patterns (g..a):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
  - dash = 40, blank = 00
- ACTIVE_LOW inversion is applied at the output register, after all pattern selection.
- Reset mid-conversion: abort immediately, no done pulse, both7seg returns to its reset value, and the next start converts normally.
- Tens nibble never exceeds 9 for values <= 99. The shift register is 7 + 8 bits wide with no extra width.

Decomposition:
- Package seg7_pkg holds:
  - state enum {IDLE, SHIFT, ENCODE}.
  - SEG_DIGIT[0:9] constant array, SEG_DASH, SEG_BLANK.
  - the localparams IN_BITS = 7 and MAX_DISPLAY = 99.
- One combinational sub-module, bcd_to_seg7: 4-bit BCD in, 7-bit pattern out, 00 for nibbles > 9. It is instantiated twice.

Test Plan:
- Reset, value = 42, 1-cycle start: busy high for 8 cycles; after edge N+8 done = 1 for exactly one cycle and both7seg = 14'h335B (66 / 5B); it stays stable afterward.
- value = 7: BLANK_LEADING = 1 gives both7seg = 14'h0007. BLANK_LEADING = 0 gives 14'h1F87.
- value = 0 gives 14'h003F. value = 100 and value = 127 each give 14'h2040 (dash / dash).
- Start with value = 55; at cycle 3 drive value = 12 and pulse start again. Result is 14'h36ED (6D / 6D), with one done pulse only.
- Start value = 99, assert rst at cycle 4. Required: busy = 0, done never pulses, both7seg = 14'h0000. Then start value = 10 gives 14'h033F after 9 cycles.
- ACTIVE_LOW = 1: reset gives 14'h3FFF; value = 88 gives 14'h0000; value = 7 with BLANK_LEADING = 1 gives 14'h3FF8.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared states, segment patterns and sizing for the 7-segment value encoder
package seg7_pkg;
  localparam int IN_BITS = 7;
  localparam int MAX_DISPLAY = 99;
  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: decodes one BCD nibble to a g..a segment pattern, dark for non-decimal codes
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // table lookup with non-decimal nibbles blanked
  always_comb seg = bcd <= 4'd9 ? SEG_DIGIT[bcd] : SEG_BLANK;
endmodule

// File: rtl/seg7_value_encoder.sv
// seg7_value_encoder: serial double-dabble of a 7-bit value into a registered two-digit segment word
module seg7_value_encoder
  import seg7_pkg::*;
#(
  parameter bit BLANK_LEADING = 1,
  parameter bit ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_BITS-1:0]   value,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [13:0]          both7seg
);
  localparam int SR_BITS = IN_BITS + 8;
  state_t state;
  logic [SR_BITS-1:0] sr;
  logic [2:0] cnt;
  logic ovf;
  logic [3:0] t_adj, u_adj;
  logic [6:0] tens_seg, units_seg, tens_pat, units_pat;
  bcd_to_seg7 u_tens (.bcd(sr[14:11]), .seg(tens_seg));
  bcd_to_seg7 u_units (.bcd(sr[10:7]), .seg(units_seg));
  // add-3 correction and final pattern selection; out-of-range values force dashes
  always_comb begin
    t_adj = sr[14:11] >= 4'd5 ? sr[14:11] + 4'd3 : sr[14:11];
    u_adj = sr[10:7] >= 4'd5 ? sr[10:7] + 4'd3 : sr[10:7];
    tens_pat = ovf ? SEG_DASH : (BLANK_LEADING && sr[14:11] == 4'd0) ? SEG_BLANK : tens_seg;
    units_pat = ovf ? SEG_DASH : units_seg;
  end
  // capture, shift seven times, then publish the decoded pair in one go
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      both7seg <= {14{ACTIVE_LOW}};
      sr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr <= {8'd0, value};
          cnt <= '0;
          ovf <= value > 7'(MAX_DISPLAY);
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          sr <= SR_BITS'({t_adj, u_adj, sr[6:0], 1'b0});
          cnt <= cnt + 3'd1;
          state <= cnt == 3'(IN_BITS - 1) ? ENCODE : SHIFT;
        end
        ENCODE: begin
          both7seg <= {14{ACTIVE_LOW}} ^ {tens_pat, units_pat};
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
